// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals of the two-port memory arbiter.
// slave = arbiter side; master = requesters plus the memory device.
interface mem_arbiter_if;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;

  logic        dm_req_valid;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic        dm_req_ready;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        dm_rsp_err;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr, dm_req_valid, dm_addr, dm_wdata, dm_we, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
           dm_req_ready, dm_rsp_valid, dm_rsp_data, dm_rsp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_addr, dm_req_valid, dm_addr, dm_wdata, dm_we, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
           dm_req_ready, dm_rsp_valid, dm_rsp_data, dm_rsp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, one
// transaction in flight; data port wins ties until the fetch starvation limit.
module mem_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int MAX_STREAK  = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  localparam logic [3:0] LP_STREAK = 4'(MAX_STREAK);
  localparam logic [3:0] LP_CNT    = 4'(MEM_LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_streak;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_owner_dm;
  logic        r_mem_en;
  logic        r_mem_we;
  logic        r_if_rsp_valid;
  logic [31:0] r_if_rsp_data;
  logic        r_dm_rsp_valid;
  logic [31:0] r_dm_rsp_data;
  logic        r_dm_rsp_err;

  logic w_open;
  logic w_grant_dm;
  logic w_grant_if;
  logic w_acc_dm;
  logic w_acc_if;
  logic w_misalign;

  // Acceptance is possible whenever no access is running, including the
  // response cycle, so back-to-back transactions lose no extra cycle.
  assign w_open     = !rst && (r_state != ACCESS);
  assign w_grant_dm = bus.dm_req_valid && !(bus.if_req_valid && (r_streak == LP_STREAK));
  assign w_grant_if = bus.if_req_valid && !w_grant_dm;
  assign w_acc_dm   = w_open && w_grant_dm;
  assign w_acc_if   = w_open && w_grant_if;
  assign w_misalign = (bus.dm_addr[1:0] != 2'b00);

  assign bus.dm_req_ready = w_acc_dm;
  assign bus.if_req_ready = w_acc_if;
  assign bus.mem_en       = r_mem_en;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.if_rsp_valid = r_if_rsp_valid;
  assign bus.if_rsp_data  = r_if_rsp_data;
  assign bus.dm_rsp_valid = r_dm_rsp_valid;
  assign bus.dm_rsp_data  = r_dm_rsp_data;
  assign bus.dm_rsp_err   = r_dm_rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_streak       <= '0;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_we           <= 1'b0;
      r_owner_dm     <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_dm_rsp_valid <= 1'b0;
      r_dm_rsp_data  <= '0;
      r_dm_rsp_err   <= 1'b0;
    end else begin
      r_if_rsp_valid <= 1'b0;
      r_dm_rsp_valid <= 1'b0;
      r_dm_rsp_err   <= 1'b0;
      r_mem_we       <= 1'b0;

      if (!bus.if_req_valid || w_acc_if)
        r_streak <= '0;
      else if (w_acc_dm && (r_streak != LP_STREAK))
        r_streak <= r_streak + 4'd1;

      case (r_state)
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_mem_en <= 1'b0;
            r_state  <= RESP;
            if (r_owner_dm) begin
              r_dm_rsp_valid <= 1'b1;
              r_dm_rsp_data  <= r_we ? 32'd0 : bus.mem_rdata;
            end else begin
              r_if_rsp_valid <= 1'b1;
              r_if_rsp_data  <= bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          if (w_acc_dm || w_acc_if) begin
            r_owner_dm <= w_acc_dm;
            r_addr     <= w_acc_dm ? bus.dm_addr : bus.if_addr;
            r_wdata    <= w_acc_dm ? bus.dm_wdata : 32'd0;
            r_we       <= w_acc_dm && bus.dm_we;
            // Misaligned data requests never touch memory; error answers next cycle.
            if (w_acc_dm && w_misalign) begin
              r_state        <= ERR;
              r_dm_rsp_valid <= 1'b1;
              r_dm_rsp_err   <= 1'b1;
              r_dm_rsp_data  <= '0;
            end else begin
              r_state  <= ACCESS;
              r_cnt    <= LP_CNT;
              r_mem_en <= 1'b1;
              r_mem_we <= w_acc_dm && bus.dm_we;
            end
          end
        end
      endcase
    end
  end

endmodule
